// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data memory: RV32I B/H/W loads/stores with RD_LAT-cycle load stall.
// Optional MISALIGN_TRAP_EN: flag and block misaligned accesses instead of forcing them aligned.
module mem_access_unit #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32,
  parameter int RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [31:0]       WriteDataM,
  input  logic              MemWriteM,
  input  logic              MemReadM,
  input  logic [2:0]        Funct3M,
  output logic [31:0]       ReadDataM,
  output logic              StallM,
  output logic              MisalignM
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} memStateT;

  memStateT         state;
  logic [2:0]       cnt;
  logic [IDX_W-1:0] latIdx;
  logic [1:0]       latLane;
  logic [2:0]       latF3;
  logic [31:0]      memArray [DEPTH_WORDS];

  logic [IDX_W-1:0] reqIdx;
  logic [1:0]       rawLane;
  logic [1:0]       reqLane;
  logic             isHalf;
  logic             isWord;
  logic             blocked;
  logic             loadAccept;
  logic             storeAccept;
  logic [3:0]       laneMask;
  logic [31:0]      storeData;
  logic             unusedAddrBits;

  assign reqIdx  = ALUResultM[IDX_W+1:2];
  assign rawLane = ALUResultM[1:0];
  assign isHalf  = (Funct3M[1:0] == 2'b01);
  assign isWord  = (Funct3M == 3'b010);

  // Upper address bits only select aliases of the same array.
  if (ADDR_W > IDX_W + 2) begin : gUpper
    assign unusedAddrBits = ^ALUResultM[ADDR_W-1:IDX_W+2];
  end else begin : gNoUpper
    assign unusedAddrBits = 1'b0;
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (isHalf && rawLane[0]) || (isWord && (rawLane != 2'b00));
  assign MisalignM  = rst_n && (MemReadM || MemWriteM) && misaligned;
  assign blocked    = misaligned;
  assign reqLane    = rawLane;
`else
  assign MisalignM = 1'b0;
  assign blocked   = 1'b0;
  assign reqLane   = isWord ? 2'b00 : (isHalf ? {rawLane[1], 1'b0} : rawLane);
`endif

  assign loadAccept  = rst_n && (state == IDLE) && MemReadM && !blocked;
  assign storeAccept = rst_n && (state == IDLE) && MemWriteM && !MemReadM && !blocked;
  assign StallM      = loadAccept || (rst_n && (state == WAIT));

  always_comb begin
    laneMask  = 4'b0000;
    storeData = WriteDataM;
    case (Funct3M)
      3'b000: begin
        laneMask  = 4'b0001 << reqLane;
        storeData = {4{WriteDataM[7:0]}};
      end
      3'b001: begin
        laneMask  = reqLane[1] ? 4'b1100 : 4'b0011;
        storeData = {2{WriteDataM[15:0]}};
      end
      3'b010:  laneMask = 4'b1111;
      default: laneMask = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (storeAccept) begin
      for (int i = 0; i < 4; i++) begin
        if (laneMask[i]) memArray[reqIdx][8*i +: 8] <= storeData[8*i +: 8];
      end
    end
  end

  function automatic logic [31:0] extendLoad(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return word;
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      latIdx    <= '0;
      latLane   <= 2'b00;
      latF3     <= 3'b000;
      ReadDataM <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (loadAccept) begin
            latIdx  <= reqIdx;
            latLane <= reqLane;
            latF3   <= Funct3M;
            cnt     <= 3'(RD_LAT - 1);
            // Single-cycle latency captures straight from the request address.
            if (RD_LAT == 1) begin
              ReadDataM <= extendLoad(memArray[reqIdx], reqLane, Funct3M);
              state     <= DONE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            ReadDataM <= extendLoad(memArray[latIdx], latLane, latF3);
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed bench driving RD_LAT=1 and RD_LAT=3 instances in lockstep.
// Honours MISALIGN_TRAP_EN to select which misalignment behaviour is expected.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        MemWriteM;
  logic        MemReadM;
  logic [2:0]  Funct3M;
  logic [31:0] rd1, rd3;
  logic        st1, st3, mis1, mis3;
  int          testsRun = 0;
  int          testsFailed = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH_WORDS(1024), .ADDR_W(32), .RD_LAT(1)) dutLat1 (
    .clk(clk), .rst_n(rst_n), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .MemWriteM(MemWriteM), .MemReadM(MemReadM), .Funct3M(Funct3M),
    .ReadDataM(rd1), .StallM(st1), .MisalignM(mis1)
  );

  mem_access_unit #(.DEPTH_WORDS(1024), .ADDR_W(32), .RD_LAT(3)) dutLat3 (
    .clk(clk), .rst_n(rst_n), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .MemWriteM(MemWriteM), .MemReadM(MemReadM), .Funct3M(Funct3M),
    .ReadDataM(rd3), .StallM(st3), .MisalignM(mis3)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the store.
  task automatic storeOp(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] data,
                         input string tag);
    ALUResultM = addr; Funct3M = f3; WriteDataM = data; MemWriteM = 1'b1; MemReadM = 1'b0;
    @(negedge clk);
    checkVal({tag, "/stall1"}, {31'h0, st1}, 32'h0);
    checkVal({tag, "/stall3"}, {31'h0, st3}, 32'h0);
    @(posedge clk); #1;
    MemWriteM = 1'b0;
  endtask

  // Inputs held four cycles: lat3 goes IDLE,WAIT,WAIT,DONE; lat1 goes IDLE,DONE twice.
  task automatic loadOp(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] exp,
                        input string tag);
    ALUResultM = addr; Funct3M = f3; MemReadM = 1'b1; MemWriteM = 1'b0;
    @(negedge clk);
    checkVal({tag, "/c0stall1"}, {31'h0, st1}, 32'h1);
    checkVal({tag, "/c0stall3"}, {31'h0, st3}, 32'h1);
    checkVal({tag, "/c0mis"}, {30'h0, mis1, mis3}, 32'h0);
    @(negedge clk);
    checkVal({tag, "/c1stall1"}, {31'h0, st1}, 32'h0);
    checkVal({tag, "/c1data1"}, rd1, exp);
    checkVal({tag, "/c1stall3"}, {31'h0, st3}, 32'h1);
    @(negedge clk);
    checkVal({tag, "/c2stall1"}, {31'h0, st1}, 32'h1);
    checkVal({tag, "/c2stall3"}, {31'h0, st3}, 32'h1);
    @(negedge clk);
    checkVal({tag, "/c3stall3"}, {31'h0, st3}, 32'h0);
    checkVal({tag, "/c3data3"}, rd3, exp);
    @(posedge clk); #1;
    MemReadM = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ALUResultM = 32'h10; WriteDataM = 32'h0; Funct3M = 3'b010;
    MemWriteM = 1'b0; MemReadM = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst/stall", {30'h0, st1, st3}, 32'h0);
    checkVal("rst/mis", {30'h0, mis1, mis3}, 32'h0);
    checkVal("rst/rd1", rd1, 32'h0);
    checkVal("rst/rd3", rd3, 32'h0);
    MemReadM = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    storeOp(32'h10, 3'b010, 32'h8000_F0A5, "sw10");
    loadOp(32'h10, 3'b000, 32'hFFFF_FFA5, "lb10");
    loadOp(32'h10, 3'b100, 32'h0000_00A5, "lbu10");
    loadOp(32'h12, 3'b001, 32'hFFFF_8000, "lh12");
    loadOp(32'h12, 3'b101, 32'h0000_8000, "lhu12");
    loadOp(32'h10, 3'b010, 32'h8000_F0A5, "lw10");

    storeOp(32'h20, 3'b010, 32'h1122_3344, "sw20");
    storeOp(32'h21, 3'b000, 32'hFFFF_FF3C, "sb21");
    loadOp(32'h20, 3'b010, 32'h1122_3C44, "lw20a");
    storeOp(32'h22, 3'b001, 32'h1234_BEEF, "sh22");
    loadOp(32'h20, 3'b010, 32'hBEEF_3C44, "lw20b");
    loadOp(32'h23, 3'b000, 32'hFFFF_FFBE, "lb23");
    loadOp(32'h21, 3'b100, 32'h0000_003C, "lbu21");
    loadOp(32'h20, 3'b001, 32'h0000_3C44, "lh20");

    storeOp(32'h20, 3'b011, 32'hFFFF_FFFF, "badst");
    loadOp(32'h20, 3'b010, 32'hBEEF_3C44, "lw20c");
    loadOp(32'h20, 3'b011, 32'h0000_0000, "badld");
    loadOp(32'h20, 3'b010, 32'hBEEF_3C44, "b2b1");
    loadOp(32'h10, 3'b010, 32'h8000_F0A5, "b2b2");

    storeOp(32'h0000_1004, 3'b010, 32'hDEAD_BEEF, "swwrap");
    loadOp(32'h4, 3'b010, 32'hDEAD_BEEF, "lwwrap");

    // Reset while the lat3 instance sits in WAIT.
    ALUResultM = 32'h10; Funct3M = 3'b010; MemReadM = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkVal("rstwait/stall3", {31'h0, st3}, 32'h0);
    checkVal("rstwait/stall1", {31'h0, st1}, 32'h0);
    checkVal("rstwait/rd3", rd3, 32'h0);
    MemReadM = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("rstwait/idle3", {31'h0, st3}, 32'h0);
    checkVal("rstwait/rd3b", rd3, 32'h0);
    @(posedge clk); #1;
    loadOp(32'h10, 3'b010, 32'h8000_F0A5, "lwpostrst");

    storeOp(32'h0, 3'b010, 32'h0000_0000, "sw0");
`ifdef MISALIGN_TRAP_EN
    loadOp(32'h4, 3'b010, 32'hDEAD_BEEF, "lw4");
    ALUResultM = 32'h6; Funct3M = 3'b010; MemReadM = 1'b1;
    @(negedge clk);
    checkVal("mislw/mis", {30'h0, mis1, mis3}, 32'h3);
    checkVal("mislw/stall", {30'h0, st1, st3}, 32'h0);
    @(posedge clk); #1;
    MemReadM = 1'b0;
    @(negedge clk);
    checkVal("mislw/rd1", rd1, 32'hDEAD_BEEF);
    checkVal("mislw/rd3", rd3, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    ALUResultM = 32'h3; Funct3M = 3'b001; WriteDataM = 32'h0000_7777; MemWriteM = 1'b1;
    @(negedge clk);
    checkVal("missh/mis", {30'h0, mis1, mis3}, 32'h3);
    @(posedge clk); #1;
    MemWriteM = 1'b0;
    loadOp(32'h0, 3'b010, 32'h0000_0000, "missh/lw0");
`else
    loadOp(32'h6, 3'b010, 32'hDEAD_BEEF, "mislw6");
    storeOp(32'h3, 3'b001, 32'h0000_7777, "missh3");
    loadOp(32'h0, 3'b010, 32'h7777_0000, "missh/lw0");
    loadOp(32'h7, 3'b001, 32'hFFFF_DEAD, "mislh7");
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
